// File: rtl/vga_frame_buffer.sv
`default_nettype none
// ==========================================================================
// vga_frame_buffer : 1bpp 160x120 frame buffer, 640x480 read addressing,
//                    pixel write port and VSYNC-aligned whole-buffer fill.
// Revision 1.0
// ==========================================================================
module vga_frame_buffer #(
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] VGA_ADDR_H,
    input  logic [9:0] VGA_ADDR_V,
    output logic       VGA_DATA,
    input  logic       VGA_VS,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic [7:0] WR_X,
    input  logic [6:0] WR_Y,
    input  logic       WR_DATA,
    input  logic       FILL_REQ,
    input  logic       FILL_VALUE,
    output logic       FILL_BUSY,
    output logic       FILL_DONE
);

    localparam int               MEM_DEPTH = H_PIXELS * V_PIXELS;
    localparam int               IDX_W     = 15;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        FILL    = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] fill_cnt_q,  fill_cnt_d;
    logic             fill_val_q,  fill_val_d;
    logic             fill_done_q, fill_done_d;
    logic             vs_prev_q,   vs_prev_d;
    logic             vga_data_q,  vga_data_d;

    logic mem [MEM_DEPTH];

    logic [9:0]       rd_x;
    logic [9:0]       rd_y;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    logic             wr_fire;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic             mem_wdata;

    // Read path: downscale the 640x480 coordinate, blank anything off the stored grid
    always_comb begin
        rd_x        = VGA_ADDR_H >> SCALE_SHIFT;
        rd_y        = VGA_ADDR_V >> SCALE_SHIFT;
        rd_in_range = (rd_x < 10'(H_PIXELS)) && (rd_y < 10'(V_PIXELS));
        rd_idx      = rd_in_range ? (IDX_W'(rd_y) * IDX_W'(H_PIXELS) + IDX_W'(rd_x))
                                  : '0;
        vga_data_d  = rd_in_range ? mem[rd_idx] : 1'b0;
    end

    always_comb begin
        WR_READY    = (state_q == IDLE) && RESET;
        wr_fire     = WR_VALID && WR_READY;
        wr_in_range = (WR_X < 8'(H_PIXELS)) && (WR_Y < 7'(V_PIXELS));
        wr_idx      = IDX_W'(WR_Y) * IDX_W'(H_PIXELS) + IDX_W'(WR_X);
    end

    // Fill and port writes never overlap: the port is only ready in IDLE
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 1'b0;
        if (state_q == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = fill_cnt_q;
            mem_wdata = fill_val_q;
        end else if (wr_fire && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            mem_wdata = WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_val_d  = fill_val_q;
        fill_done_d = 1'b0;
        vs_prev_d   = VGA_VS;
        case (state_q)
            IDLE: begin
                if (FILL_REQ) begin
                    fill_val_d = FILL_VALUE;
                    state_d    = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_prev_q && !VGA_VS) begin
                    fill_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (fill_cnt_q == LAST_IDX) begin
                    fill_cnt_d  = '0;
                    fill_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            fill_val_q  <= 1'b0;
            fill_done_q <= 1'b0;
            vs_prev_q   <= 1'b1;
            vga_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_val_q  <= fill_val_d;
            fill_done_q <= fill_done_d;
            vs_prev_q   <= vs_prev_d;
            vga_data_q  <= vga_data_d;
        end
    end

    assign VGA_DATA  = vga_data_q;
    assign FILL_BUSY = (state_q != IDLE);
    assign FILL_DONE = fill_done_q;

endmodule
`default_nettype wire
